// File: rtl/pipe_if_stage.sv
// rtl/pipe_if_stage.sv - instruction fetch stage with IF/ID register, fetch/stall counters and misalign flag
//
// Purpose: holds the PC, drives the instruction memory address, selects the
// next PC from PC+4 or one of three redirect targets, and captures the fetched
// word together with PC+4 into the IF/ID register. A high wpcir freezes the PC
// and the IF/ID register for that edge.
//
// Ports:
//   clock       in   1   rising-edge clock
//   reset       in   1   asynchronous active-high reset
//   wpcir       in   1   1 = hold PC and IF/ID (decode stall)
//   pcsource    in   2   next PC: 0 = PC+4, 1 = bpc, 2 = rpc, 3 = jpc
//   bpc         in  32   branch target
//   rpc         in  32   register (jr) target
//   jpc         in  32   jump target
//   imem_addr   out 32   instruction memory address (= PC)
//   imem_data   in  32   instruction word read combinationally at imem_addr
//   ID_inst     out 32   IF/ID instruction
//   ID_pc4      out 32   IF/ID fetch PC+4
//   ID_valid    out  1   IF/ID holds a fetched instruction
//   fetch_count out 32   non-stalled fetch edges (wrapping)
//   stall_count out 32   stalled edges (wrapping)
//   pc_misalign out  1   sticky: a selected redirect target had bits [1:0] != 0

module pipe_if_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        wpcir,
  input  logic [1:0]  pcsource,
  input  logic [31:0] bpc,
  input  logic [31:0] rpc,
  input  logic [31:0] jpc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] ID_inst,
  output logic [31:0] ID_pc4,
  output logic        ID_valid,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count,
  output logic        pc_misalign
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] id_inst_q, id_inst_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] fetch_count_q, fetch_count_d;
  logic [31:0] stall_count_q, stall_count_d;
  logic        pc_misalign_q, pc_misalign_d;

  logic [31:0] pc4;
  logic [31:0] target;
  logic [31:0] npc;
  logic        target_misaligned;

  // Next-PC selection. PC+4 is always word aligned because PC[1:0] stays 00,
  // so only the redirect targets can raise the misalign flag.
  always_comb begin
    pc4    = pc_q + 32'd4;
    target = pc4;
    unique case (pcsource)
      2'd0:    target = pc4;
      2'd1:    target = bpc;
      2'd2:    target = rpc;
      default: target = jpc;
    endcase
    target_misaligned = (pcsource != 2'd0) && (target[1:0] != 2'b00);
    npc               = {target[31:2], 2'b00};
  end

  always_comb begin
    pc_d          = pc_q;
    id_inst_d     = id_inst_q;
    id_pc4_d      = id_pc4_q;
    id_valid_d    = id_valid_q;
    fetch_count_d = fetch_count_q;
    stall_count_d = stall_count_q;
    pc_misalign_d = pc_misalign_q;
    if (wpcir) begin
      // Stall: pcsource is ignored entirely, including for the misalign flag.
      stall_count_d = stall_count_q + 32'd1;
    end else begin
      pc_d          = npc;
      id_inst_d     = imem_data;
      id_pc4_d      = pc4;
      id_valid_d    = 1'b1;
      fetch_count_d = fetch_count_q + 32'd1;
      pc_misalign_d = pc_misalign_q | target_misaligned;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q          <= 32'd0;
      id_inst_q     <= 32'd0;
      id_pc4_q      <= 32'd0;
      id_valid_q    <= 1'b0;
      fetch_count_q <= 32'd0;
      stall_count_q <= 32'd0;
      pc_misalign_q <= 1'b0;
    end else begin
      pc_q          <= pc_d;
      id_inst_q     <= id_inst_d;
      id_pc4_q      <= id_pc4_d;
      id_valid_q    <= id_valid_d;
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
      pc_misalign_q <= pc_misalign_d;
    end
  end

  assign imem_addr   = pc_q;
  assign ID_inst     = id_inst_q;
  assign ID_pc4      = id_pc4_q;
  assign ID_valid    = id_valid_q;
  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
  assign pc_misalign = pc_misalign_q;

endmodule

// File: tb/tb_pipe_if_stage.sv
// tb/tb_pipe_if_stage.sv - vector table plus scoreboard bench for pipe_if_stage

module tb_pipe_if_stage;

  logic        clock;
  logic        reset;
  logic        wpcir;
  logic [1:0]  pcsource;
  logic [31:0] bpc, rpc, jpc;
  logic [31:0] imem_addr, imem_data;
  logic [31:0] ID_inst, ID_pc4;
  logic        ID_valid;
  logic [31:0] fetch_count, stall_count;
  logic        pc_misalign;

  int total;
  int bad;

  pipe_if_stage dut (
    .clock       (clock),
    .reset       (reset),
    .wpcir       (wpcir),
    .pcsource    (pcsource),
    .bpc         (bpc),
    .rpc         (rpc),
    .jpc         (jpc),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .ID_inst     (ID_inst),
    .ID_pc4      (ID_pc4),
    .ID_valid    (ID_valid),
    .fetch_count (fetch_count),
    .stall_count (stall_count),
    .pc_misalign (pc_misalign)
  );

  // Instruction memory contents: a fixed pattern of the address, so address 0
  // reads 0x20010001 and every address gives a distinct word.
  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h20010001;
  endfunction

  assign imem_data = inst_of(imem_addr);

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        wpcir;
    logic [1:0]  psrc;
    logic [31:0] bpc;
    logic [31:0] rpc;
    logic [31:0] jpc;
    logic [31:0] e_pc;
    logic [31:0] e_pc4;
    logic [31:0] e_iaddr;
    logic        e_valid;
    logic        e_mis;
  } vec_t;

  vec_t tbl[16];
  vec_t sb[$];

  function automatic vec_t mk(input logic w, input logic [1:0] ps,
                              input logic [31:0] b, input logic [31:0] r, input logic [31:0] j,
                              input logic [31:0] epc, input logic [31:0] epc4,
                              input logic [31:0] eia, input logic ev, input logic em);
    vec_t v;
    v.wpcir = w; v.psrc = ps; v.bpc = b; v.rpc = r; v.jpc = j;
    v.e_pc = epc; v.e_pc4 = epc4; v.e_iaddr = eia; v.e_valid = ev; v.e_mis = em;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  logic [31:0] exp_fetch;
  logic [31:0] exp_stall;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t cur;
    total = 0;
    bad   = 0;
    //                w   ps     bpc           rpc           jpc           pc            pc4           inst@         v     mis
    tbl[0]  = mk(1'b0, 2'd0, 32'h00000002, 32'h00000001, 32'h00000003, 32'h00000004, 32'h00000004, 32'h00000000, 1'b1, 1'b0);
    tbl[1]  = mk(1'b0, 2'd0, 32'h0,        32'h0,        32'h0,        32'h00000008, 32'h00000008, 32'h00000004, 1'b1, 1'b0);
    tbl[2]  = mk(1'b0, 2'd0, 32'h0,        32'h0,        32'h0,        32'h0000000C, 32'h0000000C, 32'h00000008, 1'b1, 1'b0);
    tbl[3]  = mk(1'b0, 2'd3, 32'h0,        32'h0,        32'h00000008, 32'h00000008, 32'h00000010, 32'h0000000C, 1'b1, 1'b0);
    tbl[4]  = mk(1'b1, 2'd3, 32'h0,        32'h0,        32'h00000040, 32'h00000008, 32'h00000010, 32'h0000000C, 1'b1, 1'b0);
    tbl[5]  = mk(1'b1, 2'd3, 32'h0,        32'h0,        32'h00000040, 32'h00000008, 32'h00000010, 32'h0000000C, 1'b1, 1'b0);
    tbl[6]  = mk(1'b0, 2'd3, 32'h0,        32'h0,        32'h00000040, 32'h00000040, 32'h0000000C, 32'h00000008, 1'b1, 1'b0);
    tbl[7]  = mk(1'b0, 2'd3, 32'h0,        32'h0,        32'h00000010, 32'h00000010, 32'h00000044, 32'h00000040, 1'b1, 1'b0);
    tbl[8]  = mk(1'b0, 2'd1, 32'h00000100, 32'h00000003, 32'h00000001, 32'h00000100, 32'h00000014, 32'h00000010, 1'b1, 1'b0);
    tbl[9]  = mk(1'b0, 2'd2, 32'h00000002, 32'h00000024, 32'h0,        32'h00000024, 32'h00000104, 32'h00000100, 1'b1, 1'b0);
    tbl[10] = mk(1'b0, 2'd3, 32'h0,        32'h0,        32'h00000080, 32'h00000080, 32'h00000028, 32'h00000024, 1'b1, 1'b0);
    tbl[11] = mk(1'b1, 2'd2, 32'h0,        32'h00000033, 32'h0,        32'h00000080, 32'h00000028, 32'h00000024, 1'b1, 1'b0);
    tbl[12] = mk(1'b0, 2'd2, 32'h0,        32'h00000033, 32'h0,        32'h00000030, 32'h00000084, 32'h00000080, 1'b1, 1'b1);
    tbl[13] = mk(1'b0, 2'd3, 32'h0,        32'h0,        32'h00000200, 32'h00000200, 32'h00000034, 32'h00000030, 1'b1, 1'b1);
    tbl[14] = mk(1'b0, 2'd3, 32'h0,        32'h0,        32'hFFFFFFFC, 32'hFFFFFFFC, 32'h00000204, 32'h00000200, 1'b1, 1'b1);
    tbl[15] = mk(1'b0, 2'd0, 32'h0,        32'h0,        32'h0,        32'h00000000, 32'h00000000, 32'hFFFFFFFC, 1'b1, 1'b1);

    reset = 1'b1; wpcir = 1'b0; pcsource = 2'd0; bpc = 32'h0; rpc = 32'h0; jpc = 32'h0;
    exp_fetch = 32'd0;
    exp_stall = 32'd0;

    #12;
    chk("reset_pc",       imem_addr,   32'h0);
    chk("reset_id_inst",  ID_inst,     32'h0);
    chk("reset_id_pc4",   ID_pc4,      32'h0);
    chk("reset_id_valid", {31'd0, ID_valid}, 32'h0);
    chk("reset_fetch",    fetch_count, 32'h0);
    chk("reset_stall",    stall_count, 32'h0);
    chk("reset_misalign", {31'd0, pc_misalign}, 32'h0);
    reset = 1'b0;

    for (int i = 0; i < 16; i++) begin
      wpcir    = tbl[i].wpcir;
      pcsource = tbl[i].psrc;
      bpc      = tbl[i].bpc;
      rpc      = tbl[i].rpc;
      jpc      = tbl[i].jpc;
      sb.push_back(tbl[i]);
      if (tbl[i].wpcir) exp_stall++; else exp_fetch++;
      @(posedge clock);
      #1;
      if (sb.size() == 0) begin
        chk("scoreboard_empty", 32'd0, 32'd1);
      end else begin
        cur = sb.pop_front();
        chk($sformatf("v%0d_pc", i),       imem_addr, cur.e_pc);
        chk($sformatf("v%0d_id_inst", i),  ID_inst,   inst_of(cur.e_iaddr));
        chk($sformatf("v%0d_id_pc4", i),   ID_pc4,    cur.e_pc4);
        chk($sformatf("v%0d_id_valid", i), {31'd0, ID_valid},    {31'd0, cur.e_valid});
        chk($sformatf("v%0d_misalign", i), {31'd0, pc_misalign}, {31'd0, cur.e_mis});
        chk($sformatf("v%0d_fetch", i),    fetch_count, exp_fetch);
        chk($sformatf("v%0d_stall", i),    stall_count, exp_stall);
      end
    end

    // Asynchronous reset between edges while IF/ID is valid.
    wpcir = 1'b0; pcsource = 2'd3; jpc = 32'h00000080;
    #2;
    reset = 1'b1;
    #1;
    chk("async_pc",       imem_addr,   32'h0);
    chk("async_id_inst",  ID_inst,     32'h0);
    chk("async_id_pc4",   ID_pc4,      32'h0);
    chk("async_id_valid", {31'd0, ID_valid}, 32'h0);
    chk("async_fetch",    fetch_count, 32'h0);
    chk("async_stall",    stall_count, 32'h0);
    chk("async_misalign", {31'd0, pc_misalign}, 32'h0);

    // Edge during reset with a pending misaligned redirect: nothing updates.
    pcsource = 2'd2; rpc = 32'h00000077;
    @(posedge clock);
    #1;
    chk("redirect_in_reset_pc",  imem_addr, 32'h0);
    chk("redirect_in_reset_mis", {31'd0, pc_misalign}, 32'h0);

    // Reset held across a stall request, then released: first fetch is address 0.
    wpcir = 1'b1; pcsource = 2'd3; jpc = 32'h00000040;
    @(posedge clock);
    #1;
    chk("stall_in_reset_stall", stall_count, 32'h0);
    chk("stall_in_reset_pc",    imem_addr,   32'h0);
    reset = 1'b0; wpcir = 1'b0; pcsource = 2'd0;
    @(posedge clock);
    #1;
    chk("post_reset_pc",      imem_addr,   32'h00000004);
    chk("post_reset_id_inst", ID_inst,     32'h20010001);
    chk("post_reset_id_pc4",  ID_pc4,      32'h00000004);
    chk("post_reset_valid",   {31'd0, ID_valid}, 32'h1);
    chk("post_reset_fetch",   fetch_count, 32'h1);
    chk("post_reset_stall",   stall_count, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
